// File: rtl/nx_fifo_ctrl_1ar1w.sv
// FIFO controller for an external 1-async-read / 1-write RAM.
// Ports: clk/rst_n, flush, in_* push side, out_* pop side, status, ram_* RAM side.
module nx_fifo_ctrl_1ar1w #(
    parameter int WIDTH        = 64,
    parameter int DEPTH        = 256,
    parameter int AFULL_THRESH = DEPTH - 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       in_vld,
    input  logic [WIDTH-1:0]           in_dat,
    output logic                       in_rdy,
    output logic                       out_vld,
    output logic [WIDTH-1:0]           out_dat,
    input  logic                       out_rdy,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       afull,
    output logic [$clog2(DEPTH):0]     peak,
    output logic [$clog2(DEPTH)-1:0]   ram_ra,
    input  logic [WIDTH-1:0]           ram_dout,
    output logic                       ram_web,
    output logic [$clog2(DEPTH)-1:0]   ram_wa,
    output logic [WIDTH-1:0]           ram_din,
    output logic [WIDTH-1:0]           ram_bwe
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] peak_q;
    logic          afull_q;

    logic          full;
    logic          empty;
    logic          push;
    logic          pop;
    logic [CW-1:0] cnt_nxt;
    logic [CW-1:0] cnt_d;
    logic [CW-1:0] peak_d;
    logic          afull_d;

    assign full  = (cnt_q == CW'(DEPTH));
    assign empty = (cnt_q == '0);

    // rst_n gates the handshakes so reset forces them low
    // even though the counters are already zero.
    // in_rdy looks only at fullness, never at out_rdy.
    assign in_rdy  = rst_n & ~full & ~flush;
    assign out_vld = rst_n & ~empty & ~flush;

    assign push = in_vld & in_rdy;
    assign pop  = out_vld & out_rdy;

    assign ram_ra  = rptr;
    assign out_dat = ram_dout;

    assign ram_web = ~push;
    assign ram_wa  = wptr;
    assign ram_din = in_dat;
    assign ram_bwe = '1;

    always_comb begin
        cnt_nxt = cnt_q;
        unique case ({push, pop})
            2'b10:   cnt_nxt = cnt_q + 1'b1;
            2'b01:   cnt_nxt = cnt_q - 1'b1;
            default: cnt_nxt = cnt_q;
        endcase
    end

    always_comb begin
        cnt_d   = flush ? '0 : cnt_nxt;
        afull_d = (32'(cnt_d) >= AFULL_THRESH);
        peak_d  = peak_q;
        if (flush) begin
            peak_d = '0;
        end else if (cnt_nxt > peak_q) begin
            peak_d = cnt_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr    <= '0;
            rptr    <= '0;
            cnt_q   <= '0;
            peak_q  <= '0;
            afull_q <= 1'b0;
        end else begin
            if (flush) begin
                wptr <= '0;
                rptr <= '0;
            end else begin
                // DEPTH is a power of two, so pointers wrap naturally.
                if (push) wptr <= wptr + 1'b1;
                if (pop)  rptr <= rptr + 1'b1;
            end
            cnt_q   <= cnt_d;
            peak_q  <= peak_d;
            afull_q <= afull_d;
        end
    end

    assign count = cnt_q;
    assign peak  = peak_q;
    assign afull = afull_q;

endmodule

// File: tb/tb_nx_fifo_ctrl_1ar1w.sv
// Bench for nx_fifo_ctrl_1ar1w with a behavioural RAM and a queue model.
// Ports: none.
module tb_nx_fifo_ctrl_1ar1w;

    localparam int W  = 16;
    localparam int D  = 4;
    localparam int TH = 3;
    localparam int AW = $clog2(D);

    logic          clk = 1'b0;
    logic          rst_n;
    logic          flush;
    logic          in_vld;
    logic [W-1:0]  in_dat;
    logic          in_rdy;
    logic          out_vld;
    logic [W-1:0]  out_dat;
    logic          out_rdy;
    logic [AW:0]   count;
    logic          afull;
    logic [AW:0]   peak;
    logic [AW-1:0] ram_ra;
    logic [W-1:0]  ram_dout;
    logic          ram_web;
    logic [AW-1:0] ram_wa;
    logic [W-1:0]  ram_din;
    logic [W-1:0]  ram_bwe;

    nx_fifo_ctrl_1ar1w #(
        .WIDTH(W), .DEPTH(D), .AFULL_THRESH(TH)
    ) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_vld(in_vld), .in_dat(in_dat), .in_rdy(in_rdy),
        .out_vld(out_vld), .out_dat(out_dat), .out_rdy(out_rdy),
        .count(count), .afull(afull), .peak(peak),
        .ram_ra(ram_ra), .ram_dout(ram_dout), .ram_web(ram_web),
        .ram_wa(ram_wa), .ram_din(ram_din), .ram_bwe(ram_bwe)
    );

    always #5 clk = ~clk;

    logic [W-1:0] mem [D];
    int wr_cnt = 0;
    assign ram_dout = mem[ram_ra];
    always @(posedge clk) begin
        if (!ram_web) begin
            mem[ram_wa] <= (mem[ram_wa] & ~ram_bwe) | (ram_din & ram_bwe);
            wr_cnt <= wr_cnt + 1;
        end
    end

    int n_run = 0;
    int n_fail = 0;

    logic [W-1:0] q[$];
    int m_pk = 0;
    bit m_af = 0;
    bit m_psh, m_pop, m_fl;
    logic [W-1:0] m_dat;

    task automatic chk(string nm, int act, int exp);
        n_run++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive(bit v, logic [W-1:0] d, bit r, bit f);
        bit er, eo;
        in_vld = v; in_dat = d; out_rdy = r; flush = f;
        #1;
        er = (q.size() < D) && !f;
        eo = (q.size() != 0) && !f;
        chk("in_rdy", int'(in_rdy), int'(er));
        chk("out_vld", int'(out_vld), int'(eo));
        if (eo) chk("out_dat", int'(out_dat), int'(q[0]));
        chk("count", int'(count), q.size());
        chk("afull", int'(afull), int'(m_af));
        chk("peak", int'(peak), m_pk);
        m_psh = v && er;
        m_pop = r && eo;
        m_fl = f;
        m_dat = d;
        chk("ram_web", int'(ram_web), int'(!m_psh));
    endtask

    task automatic adv();
        @(posedge clk);
        if (m_fl) begin
            q.delete();
            m_pk = 0;
        end else begin
            if (m_pop) void'(q.pop_front());
            if (m_psh) q.push_back(m_dat);
            if (q.size() > m_pk) m_pk = q.size();
        end
        m_af = (q.size() >= TH);
        @(negedge clk);
    endtask

    task automatic step(bit v, logic [W-1:0] d, bit r, bit f);
        drive(v, d, r, f);
        adv();
    endtask

    typedef struct {
        bit vld; logic [W-1:0] dat; bit ordy; bit fl;
        bit e_rdy; bit e_ovld; int e_cnt; bit e_af; int e_pk;
        logic [W-1:0] e_dat;
    } vec_t;
    vec_t tbl[10];

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        tbl[0] = '{1, 16'hA1, 0, 0, 1, 0, 0, 0, 0, 16'h0};
        tbl[1] = '{1, 16'hB2, 0, 0, 1, 1, 1, 0, 1, 16'hA1};
        tbl[2] = '{1, 16'hC3, 0, 0, 1, 1, 2, 0, 2, 16'hA1};
        tbl[3] = '{1, 16'hD4, 0, 0, 1, 1, 3, 1, 3, 16'hA1};
        tbl[4] = '{0, 16'h0,  0, 0, 0, 1, 4, 1, 4, 16'hA1};
        tbl[5] = '{0, 16'h0,  1, 0, 0, 1, 4, 1, 4, 16'hA1};
        tbl[6] = '{0, 16'h0,  1, 0, 1, 1, 3, 1, 4, 16'hB2};
        tbl[7] = '{0, 16'h0,  1, 0, 1, 1, 2, 0, 4, 16'hC3};
        tbl[8] = '{0, 16'h0,  1, 0, 1, 1, 1, 0, 4, 16'hD4};
        tbl[9] = '{0, 16'h0,  0, 0, 1, 0, 0, 0, 4, 16'h0};

        rst_n = 0; flush = 0; in_vld = 1; in_dat = 16'h5A; out_rdy = 1;
        #7;
        chk("rst in_rdy", int'(in_rdy), 0);
        chk("rst out_vld", int'(out_vld), 0);
        chk("rst ram_web", int'(ram_web), 1);
        chk("rst count", int'(count), 0);
        chk("rst peak", int'(peak), 0);
        chk("rst afull", int'(afull), 0);
        @(negedge clk);
        rst_n = 1;

        for (int i = 0; i < 10; i++) begin
            drive(tbl[i].vld, tbl[i].dat, tbl[i].ordy, tbl[i].fl);
            chk("tbl in_rdy", int'(in_rdy), int'(tbl[i].e_rdy));
            chk("tbl out_vld", int'(out_vld), int'(tbl[i].e_ovld));
            chk("tbl count", int'(count), tbl[i].e_cnt);
            chk("tbl afull", int'(afull), int'(tbl[i].e_af));
            chk("tbl peak", int'(peak), tbl[i].e_pk);
            if (tbl[i].e_ovld)
                chk("tbl out_dat", int'(out_dat), int'(tbl[i].e_dat));
            adv();
        end

        drive(1, 16'h11, 0, 0);
        chk("lat pre out_vld", int'(out_vld), 0);
        adv();
        drive(0, 16'h0, 0, 0);
        chk("lat post out_vld", int'(out_vld), 1);
        chk("lat post out_dat", int'(out_dat), 16'h11);
        adv();

        for (int i = 0; i < 10; i++) begin
            drive(1, 16'h100 + 16'(i), 1, 0);
            chk("pp count", int'(count), 1);
            if (i == 0) chk("pp dat", int'(out_dat), 16'h11);
            else chk("pp dat", int'(out_dat), 16'h100 + i - 1);
            adv();
        end
        drive(0, 16'h0, 0, 0);
        chk("pp last", int'(out_dat), 16'h109);
        adv();

        for (int i = 0; i < 3; i++) step(1, 16'h200 + 16'(i), 0, 0);
        drive(1, 16'h2FF, 1, 0);
        chk("full in_rdy", int'(in_rdy), 0);
        chk("full ram_web", int'(ram_web), 1);
        adv();
        drive(0, 16'h0, 0, 0);
        chk("full count", int'(count), 3);
        chk("full head", int'(out_dat), 16'h200);
        adv();

        step(0, 16'h0, 0, 1);
        for (int i = 0; i < 3; i++) step(1, 16'h300 + 16'(i), 0, 0);
        drive(1, 16'h3FF, 1, 1);
        chk("fl count", int'(count), 3);
        chk("fl peak", int'(peak), 3);
        chk("fl ram_web", int'(ram_web), 1);
        adv();
        drive(0, 16'h0, 0, 0);
        chk("fl post count", int'(count), 0);
        chk("fl post peak", int'(peak), 0);
        chk("fl post out_vld", int'(out_vld), 0);
        adv();

        step(1, 16'h401, 0, 0);
        step(1, 16'h402, 0, 0);
        in_vld = 1; in_dat = 16'h403; out_rdy = 0; flush = 0;
        #3;
        rst_n = 0;
        #1;
        q.delete(); m_pk = 0; m_af = 0;
        chk("ar in_rdy", int'(in_rdy), 0);
        chk("ar out_vld", int'(out_vld), 0);
        chk("ar ram_web", int'(ram_web), 1);
        chk("ar count", int'(count), 0);
        chk("ar peak", int'(peak), 0);
        begin
            int snap;
            snap = wr_cnt;
            repeat (2) @(posedge clk);
            @(negedge clk);
            chk("ar no write", wr_cnt, snap);
        end
        chk("ar afull", int'(afull), 0);
        rst_n = 1;
        drive(1, 16'h501, 0, 0);
        chk("ar first rdy", int'(in_rdy), 1);
        adv();

        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 1)), W'($urandom),
                 1'($urandom_range(0, 1)), ($urandom_range(0, 24) == 0));
        end
        for (int i = 0; i < 6; i++) step(0, 16'h0, 1, 0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
